// File: rtl/axil_master_param.sv
// axil_master_param: parametrised AXI4-Lite master with one transaction outstanding.
//
// Accepts a read or write command on a valid/ready port and runs it on the AXI4-Lite
// channels. It issues AW and W concurrently and returns BRESP/RRESP plus read data on a
// one-cycle response pulse. Every output comes straight from a register.
//
// Optional feature, enabled by defining AXIL_MASTER_TIMEOUT_EN:
//   A watchdog aborts a transaction that has been busy for TIMEOUT_CYC cycles. The abort
//   reports SLVERR with o_rsp_timeout=1.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   i_cmd_*/o_cmd_ready      command: valid, write, addr, wdata, wstrb
//   o_rsp_*                  response: valid pulse, rdata, resp, timeout
//   o_m_aw*/i_m_awready      AXI write address channel
//   o_m_w*/i_m_wready        AXI write data channel
//   i_m_b*/o_m_bready        AXI write response channel
//   o_m_ar*/i_m_arready      AXI read address channel
//   i_m_r*/o_m_rready        AXI read data channel
module axil_master_param #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic                i_cmd_write,
  input  logic [ADDR_W-1:0]   i_cmd_addr,
  input  logic [DATA_W-1:0]   i_cmd_wdata,
  input  logic [DATA_W/8-1:0] i_cmd_wstrb,
  output logic                o_rsp_valid,
  output logic [DATA_W-1:0]   o_rsp_rdata,
  output logic [1:0]          o_rsp_resp,
  output logic                o_rsp_timeout,
  output logic [ADDR_W-1:0]   o_m_awaddr,
  output logic [2:0]          o_m_awprot,
  output logic                o_m_awvalid,
  input  logic                i_m_awready,
  output logic [DATA_W-1:0]   o_m_wdata,
  output logic [DATA_W/8-1:0] o_m_wstrb,
  output logic                o_m_wvalid,
  input  logic                i_m_wready,
  input  logic [1:0]          i_m_bresp,
  input  logic                i_m_bvalid,
  output logic                o_m_bready,
  output logic [ADDR_W-1:0]   o_m_araddr,
  output logic [2:0]          o_m_arprot,
  output logic                o_m_arvalid,
  input  logic                i_m_arready,
  input  logic [DATA_W-1:0]   i_m_rdata,
  input  logic [1:0]          i_m_rresp,
  input  logic                i_m_rvalid,
  output logic                o_m_rready
);

  typedef enum logic [2:0] {StIdle, StWr, StWrB, StRdA, StRdR} state_e;

  state_e r_state, w_state_d;

  logic                r_cmd_ready,   w_cmd_ready_d;
  logic                r_rsp_valid,   w_rsp_valid_d;
  logic [DATA_W-1:0]   r_rsp_rdata,   w_rsp_rdata_d;
  logic [1:0]          r_rsp_resp,    w_rsp_resp_d;
  logic                r_rsp_timeout, w_rsp_timeout_d;
  logic [ADDR_W-1:0]   r_awaddr,      w_awaddr_d;
  logic                r_awvalid,     w_awvalid_d;
  logic [DATA_W-1:0]   r_wdata,       w_wdata_d;
  logic [DATA_W/8-1:0] r_wstrb,       w_wstrb_d;
  logic                r_wvalid,      w_wvalid_d;
  logic                r_bready,      w_bready_d;
  logic [ADDR_W-1:0]   r_araddr,      w_araddr_d;
  logic                r_arvalid,     w_arvalid_d;
  logic                r_rready,      w_rready_d;

  logic w_accept;
  logic w_aw_done;
  logic w_w_done;
  logic w_timeout;

  assign w_accept  = i_cmd_valid && r_cmd_ready;
  // A channel counts as done if its valid already dropped or handshakes this cycle.
  assign w_aw_done = !r_awvalid || i_m_awready;
  assign w_w_done  = !r_wvalid || i_m_wready;

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int unsigned          CntW    = $clog2(TIMEOUT_CYC);
  // Counter is 0 in the first busy cycle, so firing at TIMEOUT_CYC-2 puts the
  // abort on the outputs exactly TIMEOUT_CYC cycles after accept.
  localparam logic [CntW-1:0]      CntLast = CntW'(TIMEOUT_CYC - 2);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (r_state != StIdle) begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign w_timeout = (r_state != StIdle) && (r_cnt == CntLast);
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYC > 1);
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_d = i_cmd_write ? StWr : StRdA;
      StWr:    if (w_aw_done && w_w_done) w_state_d = StWrB;
      StWrB:   if (i_m_bvalid && r_bready) w_state_d = StIdle;
      StRdA:   if (r_arvalid && i_m_arready) w_state_d = StRdR;
      StRdR:   if (i_m_rvalid && r_rready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    if (w_timeout) w_state_d = StIdle;
  end

  // Next values of the registered outputs
  always_comb begin
    w_cmd_ready_d   = r_cmd_ready;
    w_rsp_valid_d   = 1'b0;
    w_rsp_rdata_d   = r_rsp_rdata;
    w_rsp_resp_d    = r_rsp_resp;
    w_rsp_timeout_d = 1'b0;
    w_awaddr_d      = r_awaddr;
    w_awvalid_d     = r_awvalid;
    w_wdata_d       = r_wdata;
    w_wstrb_d       = r_wstrb;
    w_wvalid_d      = r_wvalid;
    w_bready_d      = r_bready;
    w_araddr_d      = r_araddr;
    w_arvalid_d     = r_arvalid;
    w_rready_d      = r_rready;

    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_cmd_ready_d = 1'b0;
          if (i_cmd_write) begin
            w_awaddr_d  = i_cmd_addr;
            w_wdata_d   = i_cmd_wdata;
            w_wstrb_d   = i_cmd_wstrb;
            w_awvalid_d = 1'b1;
            w_wvalid_d  = 1'b1;
          end else begin
            w_araddr_d  = i_cmd_addr;
            w_arvalid_d = 1'b1;
          end
        end
      end
      StWr: begin
        if (r_awvalid && i_m_awready) w_awvalid_d = 1'b0;
        if (r_wvalid && i_m_wready)   w_wvalid_d  = 1'b0;
        if (w_aw_done && w_w_done)    w_bready_d  = 1'b1;
      end
      StWrB: begin
        if (i_m_bvalid && r_bready) begin
          w_bready_d    = 1'b0;
          w_rsp_valid_d = 1'b1;
          w_rsp_resp_d  = i_m_bresp;
          w_cmd_ready_d = 1'b1;
        end
      end
      StRdA: begin
        if (r_arvalid && i_m_arready) begin
          w_arvalid_d = 1'b0;
          w_rready_d  = 1'b1;
        end
      end
      StRdR: begin
        if (i_m_rvalid && r_rready) begin
          w_rready_d    = 1'b0;
          w_rsp_valid_d = 1'b1;
          w_rsp_rdata_d = i_m_rdata;
          w_rsp_resp_d  = i_m_rresp;
          w_cmd_ready_d = 1'b1;
        end
      end
      default: ;
    endcase

    // Watchdog abort wins over anything else and drops every handshake signal.
    if (w_timeout) begin
      w_awvalid_d     = 1'b0;
      w_wvalid_d      = 1'b0;
      w_bready_d      = 1'b0;
      w_arvalid_d     = 1'b0;
      w_rready_d      = 1'b0;
      w_rsp_valid_d   = 1'b1;
      w_rsp_timeout_d = 1'b1;
      w_rsp_resp_d    = 2'b10;
      w_rsp_rdata_d   = r_rsp_rdata;
      w_cmd_ready_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_resp    <= 2'b00;
      r_rsp_timeout <= 1'b0;
      r_awaddr      <= '0;
      r_awvalid     <= 1'b0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_wvalid      <= 1'b0;
      r_bready      <= 1'b0;
      r_araddr      <= '0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
    end else begin
      r_cmd_ready   <= w_cmd_ready_d;
      r_rsp_valid   <= w_rsp_valid_d;
      r_rsp_rdata   <= w_rsp_rdata_d;
      r_rsp_resp    <= w_rsp_resp_d;
      r_rsp_timeout <= w_rsp_timeout_d;
      r_awaddr      <= w_awaddr_d;
      r_awvalid     <= w_awvalid_d;
      r_wdata       <= w_wdata_d;
      r_wstrb       <= w_wstrb_d;
      r_wvalid      <= w_wvalid_d;
      r_bready      <= w_bready_d;
      r_araddr      <= w_araddr_d;
      r_arvalid     <= w_arvalid_d;
      r_rready      <= w_rready_d;
    end
  end

  assign o_cmd_ready   = r_cmd_ready;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_rdata   = r_rsp_rdata;
  assign o_rsp_resp    = r_rsp_resp;
  assign o_rsp_timeout = r_rsp_timeout;
  assign o_m_awaddr    = r_awaddr;
  assign o_m_awprot    = 3'b000;
  assign o_m_awvalid   = r_awvalid;
  assign o_m_wdata     = r_wdata;
  assign o_m_wstrb     = r_wstrb;
  assign o_m_wvalid    = r_wvalid;
  assign o_m_bready    = r_bready;
  assign o_m_araddr    = r_araddr;
  assign o_m_arprot    = 3'b000;
  assign o_m_arvalid   = r_arvalid;
  assign o_m_rready    = r_rready;

endmodule
